// File: rtl/addsub_sat_pipe_if.sv
// Handshake and data bundle for the pipelined saturating add/sub unit.
// The master side drives the operands and the result-accept signal; the slave side is the datapath.
interface addsub_sat_pipe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [LANES-1:0] out_ovfl;
    logic             clr_sticky;
    logic [LANES-1:0] ovfl_sticky;

    modport master (
        output in_valid, op, A, B, out_ready, clr_sticky,
        input  in_ready, out_valid, out_sum, out_ovfl, ovfl_sticky
    );

    modport slave (
        input  in_valid, op, A, B, out_ready, clr_sticky,
        output in_ready, out_valid, out_sum, out_ovfl, ovfl_sticky
    );
endinterface

// File: rtl/addsub_sat_pipe.sv
// Two-stage saturating SIMD add/sub with a per-lane saturating accumulator and sticky overflow.
// S1 registers the op; S2 holds the saturated result until the consumer takes it.
module addsub_sat_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    addsub_sat_pipe_if.slave  bus
);
    localparam int unsigned LANE_W = WIDTH / LANES;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] acc;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [LANES-1:0] out_ovfl_q;
    logic [LANES-1:0] sticky_q;

    logic [WIDTH-1:0] res_sum;
    logic [LANES-1:0] res_ovfl;
    logic [WIDTH-1:0] acc_nxt;
    logic             load;
    logic             accept;
    logic             in_ready_c;

    // S2 may take a new op whenever it is empty or being drained this cycle.
    assign load       = s1_valid & (~out_valid_q | bus.out_ready);
    assign in_ready_c = ~rst & (~s1_valid | ~out_valid_q | bus.out_ready);
    assign accept     = bus.in_valid & in_ready_c;

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.out_ovfl    = out_ovfl_q;
    assign bus.ovfl_sticky = sticky_q;

    // Per-lane arithmetic; SUB folds into an add of ~B with carry-in, so one overflow rule covers all ops.
    always_comb begin
        logic [LANE_W-1:0] x;
        logic [LANE_W-1:0] y;
        logic [LANE_W-1:0] s;
        logic [LANE_W-1:0] sat;
        logic [LANE_W-1:0] lane_res;
        logic              cin;
        logic              ov;

        res_sum  = '0;
        res_ovfl = '0;
        acc_nxt  = acc;
        x        = '0;
        y        = '0;
        s        = '0;
        sat      = '0;
        lane_res = '0;
        cin      = 1'b0;
        ov       = 1'b0;

        for (int unsigned i = 0; i < LANES; i++) begin
            x   = (s1_op == OP_ACC) ? acc[i*LANE_W +: LANE_W] : s1_a[i*LANE_W +: LANE_W];
            cin = (s1_op == OP_SUB);
            case (s1_op)
                OP_SUB:  y = ~s1_b[i*LANE_W +: LANE_W];
                OP_ACC:  y = s1_a[i*LANE_W +: LANE_W];
                default: y = s1_b[i*LANE_W +: LANE_W];
            endcase
            s   = x + y + LANE_W'(cin);
            ov  = (x[LANE_W-1] == y[LANE_W-1]) && (s[LANE_W-1] != x[LANE_W-1]);
            sat = x[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
            lane_res = ov ? sat : s;

            res_sum[i*LANE_W +: LANE_W] = lane_res;
            res_ovfl[i]                 = ov;
            if (s1_op == OP_ACC) begin
                acc_nxt[i*LANE_W +: LANE_W] = lane_res;
            end
        end

        // CLR reports the old accumulator and empties it.
        if (s1_op == OP_CLR) begin
            res_sum  = acc;
            res_ovfl = '0;
            acc_nxt  = '0;
        end
    end

    // Stage registers, accumulator and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_op       <= OP_ADD;
            s1_a        <= '0;
            s1_b        <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovfl_q  <= '0;
            sticky_q    <= '0;
        end else begin
            s1_valid <= accept | (s1_valid & ~load);
            if (accept) begin
                s1_op <= op_e'(bus.op);
                s1_a  <= bus.A;
                s1_b  <= bus.B;
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= res_sum;
                out_ovfl_q  <= res_ovfl;
                acc         <= acc_nxt;
                sticky_q    <= (bus.clr_sticky ? '0 : sticky_q) | res_ovfl;
            end else begin
                if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end
                if (bus.clr_sticky) begin
                    sticky_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Directed bench for addsub_sat_pipe: streamed vector tables for a scalar and a 4-lane instance,
// plus hand sequences for backpressure, sticky flags and reset mid-flight.
module tb_addsub_sat_pipe;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic [3:0]  ovfl;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t tbl[$];

    addsub_sat_pipe_if #(.WIDTH(16), .LANES(1)) bus1 ();
    addsub_sat_pipe_if #(.WIDTH(16), .LANES(4)) bus4 ();

    addsub_sat_pipe #(.WIDTH(16), .LANES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    addsub_sat_pipe #(.WIDTH(16), .LANES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] sum, input logic [3:0] ovfl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sum = sum; v.ovfl = ovfl;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit use4, input logic v, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (use4) begin
            bus4.in_valid = v; bus4.op = op; bus4.A = a; bus4.B = b;
        end else begin
            bus1.in_valid = v; bus1.op = op; bus1.A = a; bus1.B = b;
        end
    endtask

    // Issues the table back-to-back; row i must be on the output right after the edge following its acceptance.
    task automatic run_tbl(input bit use4);
        logic        ov;
        logic [15:0] s;
        logic [3:0]  f;
        int          n;
        n = tbl.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(use4, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
            else       drive(use4, 1'b0, ADD, 16'h0, 16'h0);
            @(posedge clk); #1;
            if (use4) begin
                ov = bus4.out_valid; s = bus4.out_sum; f = bus4.out_ovfl;
            end else begin
                ov = bus1.out_valid; s = bus1.out_sum; f = {3'b000, bus1.out_ovfl};
            end
            if (i >= 1) begin
                check($sformatf("lanes%0d_row%0d.valid", use4 ? 4 : 1, i - 1), 32'(ov), 32'd1);
                check($sformatf("lanes%0d_row%0d.sum", use4 ? 4 : 1, i - 1), 32'(s), 32'(tbl[i-1].sum));
                check($sformatf("lanes%0d_row%0d.ovfl", use4 ? 4 : 1, i - 1), 32'(f), 32'(tbl[i-1].ovfl));
            end
        end
        @(posedge clk); #1;
        ov = use4 ? bus4.out_valid : bus1.out_valid;
        check($sformatf("lanes%0d.drained", use4 ? 4 : 1), 32'(ov), 32'd0);
        tbl.delete();
    endtask

    initial begin
        logic [15:0] bp_exp [3];
        int sent, rcv, first, last;
        logic fire_in, fire_out;

        n_checks = 0;
        n_fail   = 0;
        bp_exp[0] = 16'h0002; bp_exp[1] = 16'h0004; bp_exp[2] = 16'h0006;
        drive(1'b0, 1'b0, ADD, 16'h0, 16'h0);
        drive(1'b1, 1'b0, ADD, 16'h0, 16'h0);
        bus1.out_ready = 1'b1; bus1.clr_sticky = 1'b0;
        bus4.out_ready = 1'b1; bus4.clr_sticky = 1'b0;

        // Reset state
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst.in_ready", 32'(bus1.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst.out_sum", 32'(bus1.out_sum), 32'd0);
        check("rst.out_ovfl", 32'(bus1.out_ovfl), 32'd0);
        check("rst.sticky", 32'(bus1.ovfl_sticky), 32'd0);
        check("rst.out_valid4", 32'(bus4.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(bus1.in_ready), 32'd1);

        // Scalar saturation and accumulator, streamed back-to-back
        add(ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 4'h1);
        add(SUB, 16'h8000, 16'h0001, 16'h8000, 4'h1);
        add(SUB, 16'h0005, 16'h0007, 16'hFFFE, 4'h0);
        add(ADD, 16'h8000, 16'hFFFF, 16'h8000, 4'h1);
        add(SUB, 16'h0000, 16'h8000, 16'h7FFF, 4'h1);
        add(ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'h0);
        add(CLR, 16'h0000, 16'h0000, 16'h0000, 4'h0);
        add(ACC, 16'h4000, 16'h5555, 16'h4000, 4'h0);
        add(ACC, 16'h4000, 16'h5555, 16'h7FFF, 4'h1);
        add(ACC, 16'h4000, 16'h5555, 16'h7FFF, 4'h1);
        add(CLR, 16'h0000, 16'h0000, 16'h7FFF, 4'h0);
        add(ACC, 16'h0001, 16'h0000, 16'h0001, 4'h0);
        add(ACC, 16'hFFFE, 16'h1234, 16'hFFFF, 4'h0);
        add(CLR, 16'h0000, 16'h0000, 16'hFFFF, 4'h0);
        run_tbl(1'b0);

        // Packed 4-bit lanes
        add(ADD, 16'h78F1, 16'h1811, 16'h7802, 4'b1100);
        add(SUB, 16'h1234, 16'h2222, 16'hF012, 4'b0000);
        add(SUB, 16'h8000, 16'h1000, 16'h8000, 4'b1000);
        add(ACC, 16'h4321, 16'h0000, 16'h4321, 4'b0000);
        add(ACC, 16'h4F71, 16'h0000, 16'h7272, 4'b1010);
        add(CLR, 16'h0000, 16'h0000, 16'h7272, 4'b0000);
        run_tbl(1'b1);
        check("lanes4.sticky", 32'(bus4.ovfl_sticky), 32'hE);

        // Backpressure: consumer stalls 4 cycles while 3 ADDs are offered
        sent = 0; rcv = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus1.out_ready = (cyc >= 4);
            drive(1'b0, sent < 3, ADD, 16'(sent + 1), 16'(sent + 1));
            #1;
            if (cyc == 2 || cyc == 3) begin
                check($sformatf("bp.in_ready_low%0d", cyc), 32'(bus1.in_ready), 32'd0);
                check($sformatf("bp.hold_valid%0d", cyc), 32'(bus1.out_valid), 32'd1);
                check($sformatf("bp.hold_sum%0d", cyc), 32'(bus1.out_sum), 32'h0002);
            end
            fire_in  = bus1.in_valid & bus1.in_ready;
            fire_out = bus1.out_valid & bus1.out_ready;
            if (fire_out) begin
                if (rcv < 3) check($sformatf("bp.result%0d", rcv), 32'(bus1.out_sum), 32'(bp_exp[rcv]));
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            @(posedge clk);
            if (fire_in) sent++;
            #1;
        end
        check("bp.sent", 32'(sent), 32'd3);
        check("bp.received", 32'(rcv), 32'd3);
        check("bp.one_per_cycle", 32'(last - first), 32'd2);
        bus1.out_ready = 1'b1;

        // Sticky flags
        check("sticky.held", 32'(bus1.ovfl_sticky), 32'd1);
        bus1.clr_sticky = 1'b1;
        @(posedge clk); #1;
        bus1.clr_sticky = 1'b0;
        check("sticky.cleared", 32'(bus1.ovfl_sticky), 32'd0);
        drive(1'b0, 1'b1, ADD, 16'h7FFF, 16'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, ADD, 16'h0, 16'h0);
        bus1.clr_sticky = 1'b1;
        check("sticky.before_load", 32'(bus1.ovfl_sticky), 32'd0);
        @(posedge clk); #1;
        bus1.clr_sticky = 1'b0;
        check("sticky.clr_with_load", 32'(bus1.ovfl_sticky), 32'd1);
        check("sticky.load_ovfl", 32'(bus1.out_ovfl), 32'd1);
        @(posedge clk); #1;

        // Reset with two ops buffered and acc = 0x1234
        add(CLR, 16'h0000, 16'h0000, 16'h0000, 4'h0);
        add(ACC, 16'h1234, 16'h0000, 16'h1234, 4'h0);
        run_tbl(1'b0);
        bus1.clr_sticky = 1'b1;
        @(posedge clk); #1;
        bus1.clr_sticky = 1'b0;
        bus1.out_ready = 1'b0;
        drive(1'b0, 1'b1, ADD, 16'h7FFF, 16'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, ADD, 16'h0001, 16'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, ADD, 16'h0, 16'h0);
        check("mid.full_in_ready", 32'(bus1.in_ready), 32'd0);
        check("mid.sticky_set", 32'(bus1.ovfl_sticky), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst.out_valid", 32'(bus1.out_valid), 32'd0);
        check("mid_rst.in_ready", 32'(bus1.in_ready), 32'd0);
        check("mid_rst.sticky", 32'(bus1.ovfl_sticky), 32'd0);
        rst = 1'b0;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_rst.no_leak", 32'(bus1.out_valid), 32'd0);
        add(ACC, 16'h0001, 16'h0000, 16'h0001, 4'h0);
        run_tbl(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
